sh4_fpwb: RTL and testbench

//  Writeback collector for the SH4 FP register file (sh4_fprf). It accepts results from two producers:
//  the FPU pipeline and the load/store unit (FMOV loads). Each producer has a valid/ready queue.
//  The block drives both FPRF write ports every cycle, splitting 64-bit DRn/XDn writes across the port pair.
//  It also exports a pending-write bitmap so decode can stall on registers that have a write queued.

---
 rtl/sh4_fpwb_pkg.sv | 39 +++
 rtl/sh4_fpwb_if.sv | 52 +++++
 rtl/sh4_fpwb_fifo.sv | 68 ++++++
 rtl/sh4_fpwb.sv | 160 ++++++++++++++++
 tb/tb_sh4_fpwb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sh4_fpwb_pkg.sv
// Shared types and constants for the SH4 FP register-file writeback collector.
// Entry layout keeps {dbl,bank,dst} in the top bits so the FIFO can expose a
// narrow tag view of every slot for the busy map.
package sh4_fpwb_pkg;

  localparam int FPWB_DEPTH = 2;

  typedef struct packed {
    logic        dbl;
    logic        bank;
    logic [3:0]  dst;
    logic [63:0] data;
  } wb_ent_t;

  localparam int ENT_W = $bits(wb_ent_t);
  // {dbl, bank, dst} at the MSB end of an entry
  localparam int TAG_W = 6;

  // Arbiter preference: which producer wins the next conflicting cycle
  typedef enum logic {
    RR_FPU = 1'b0,
    RR_LSU = 1'b1
  } rr_e;

  // One-hot (single) or two-hot (double pair) register mask, bit = bank*16+reg
  function automatic logic [31:0] busy_mask(input logic dbl, input logic bank,
                                            input logic [3:0] dst);
    logic [31:0] m;
    m = '0;
    if (dbl) begin
      m[{bank, dst[3:1], 1'b0}] = 1'b1;
      m[{bank, dst[3:1], 1'b1}] = 1'b1;
    end else begin
      m[{bank, dst}] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sh4_fpwb_if.sv
// Bus bundle for the writeback collector: two producer valid/ready channels
// (FPU, LSU), the two FPRF write ports, and the pending-write status.
// master = producers + FPRF/decode side, slave = the collector.
interface sh4_fpwb_if;

  logic        fpu_wb_valid;
  logic        fpu_wb_ready;
  logic [3:0]  fpu_wb_dst;
  logic        fpu_wb_bank;
  logic        fpu_wb_dbl;
  logic [63:0] fpu_wb_data;

  logic        lsu_wb_valid;
  logic        lsu_wb_ready;
  logic [3:0]  lsu_wb_dst;
  logic        lsu_wb_bank;
  logic        lsu_wb_dbl;
  logic [63:0] lsu_wb_data;

  logic        rf_wen0;
  logic [3:0]  rf_wdst0;
  logic        rf_wbank0;
  logic [31:0] rf_wdata0;
  logic        rf_wen1;
  logic [3:0]  rf_wdst1;
  logic        rf_wbank1;
  logic [31:0] rf_wdata1;

  logic [31:0] wb_busy;
  logic        wb_idle;

  modport master (
    output fpu_wb_valid, fpu_wb_dst, fpu_wb_bank, fpu_wb_dbl, fpu_wb_data,
    input  fpu_wb_ready,
    output lsu_wb_valid, lsu_wb_dst, lsu_wb_bank, lsu_wb_dbl, lsu_wb_data,
    input  lsu_wb_ready,
    input  rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0,
    input  rf_wen1, rf_wdst1, rf_wbank1, rf_wdata1,
    input  wb_busy, wb_idle
  );

  modport slave (
    input  fpu_wb_valid, fpu_wb_dst, fpu_wb_bank, fpu_wb_dbl, fpu_wb_data,
    output fpu_wb_ready,
    input  lsu_wb_valid, lsu_wb_dst, lsu_wb_bank, lsu_wb_dbl, lsu_wb_data,
    output lsu_wb_ready,
    output rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0,
    output rf_wen1, rf_wdst1, rf_wbank1, rf_wdata1,
    output wb_busy, wb_idle
  );

endinterface

// File: rtl/sh4_fpwb_fifo.sv
// Purpose: synchronous FIFO with async active-high reset and a per-slot view.
// Latency: a push is visible at o_head_dat the cycle after the push edge.
// Backpressure: o_full blocks pushes; push and pop may share an edge when not full.
// Ports: i_clk/i_rst; i_push/i_push_dat; i_pop; o_head_dat, o_empty, o_full;
//        o_ent_vld/o_ent_tag give every slot's occupancy and its top TAG_W bits.
module sh4_fpwb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 70,
  parameter int TAG_W = 6
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_push_dat,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head_dat,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [DEPTH-1:0]            o_ent_vld,
  output logic [DEPTH-1:0][TAG_W-1:0] o_ent_tag
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit above the index
  logic [AW:0]                   r_wr_ptr;
  logic [AW:0]                   r_rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]   r_mem;
  logic [AW:0]                   w_count;
  logic                          w_push;
  logic                          w_pop;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mem    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Slot i is live when its distance from the read index is below the count
  always_comb begin
    o_ent_vld = '0;
    o_ent_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_vld[i] = ({1'b0, AW'(i) - r_rd_ptr[AW-1:0]} < w_count);
      o_ent_tag[i] = r_mem[i][WIDTH-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/sh4_fpwb.sv
// Purpose: FPRF writeback collector; queues FPU and LSU results, drives both write ports.
// Latency: entry accepted at edge N drives rf_* in the following cycle, pops with the write.
// Backpressure: *_wb_ready = queue not full; conflicting heads alternate round-robin.
// Ports: i_clk, i_rst (async, active-high); io_wb carries both producer channels,
//        FPRF write ports 0/1, wb_busy pending-write map and wb_idle.
module sh4_fpwb
  import sh4_fpwb_pkg::*;
#(
  parameter int DEPTH = FPWB_DEPTH
) (
  input  logic       i_clk,
  input  logic       i_rst,
  sh4_fpwb_if.slave  io_wb
);

  wb_ent_t                     w_f_push_ent;
  wb_ent_t                     w_l_push_ent;
  wb_ent_t                     w_f_head;
  wb_ent_t                     w_l_head;
  wb_ent_t                     w_sel;
  logic                        w_f_empty, w_f_full, w_f_pop, w_f_vld;
  logic                        w_l_empty, w_l_full, w_l_pop, w_l_vld;
  logic [DEPTH-1:0]            w_f_ent_vld, w_l_ent_vld;
  logic [DEPTH-1:0][TAG_W-1:0] w_f_ent_tag, w_l_ent_tag;
  logic                        w_conflict;
  rr_e                         r_rr_ptr;
  rr_e                         w_rr_next;

  logic                        w_wen0, w_wen1, w_wbank0, w_wbank1;
  logic [3:0]                  w_wdst0, w_wdst1;
  logic [31:0]                 w_wdata0, w_wdata1;
  logic [31:0]                 w_busy;

  assign w_f_push_ent = '{dbl:  io_wb.fpu_wb_dbl,  bank: io_wb.fpu_wb_bank,
                          dst:  io_wb.fpu_wb_dst,  data: io_wb.fpu_wb_data};
  assign w_l_push_ent = '{dbl:  io_wb.lsu_wb_dbl,  bank: io_wb.lsu_wb_bank,
                          dst:  io_wb.lsu_wb_dst,  data: io_wb.lsu_wb_data};

  sh4_fpwb_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W), .TAG_W(TAG_W)) u_fpu_q (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (io_wb.fpu_wb_valid),
    .i_push_dat (w_f_push_ent),
    .i_pop      (w_f_pop),
    .o_head_dat (w_f_head),
    .o_empty    (w_f_empty),
    .o_full     (w_f_full),
    .o_ent_vld  (w_f_ent_vld),
    .o_ent_tag  (w_f_ent_tag)
  );

  sh4_fpwb_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W), .TAG_W(TAG_W)) u_lsu_q (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (io_wb.lsu_wb_valid),
    .i_push_dat (w_l_push_ent),
    .i_pop      (w_l_pop),
    .o_head_dat (w_l_head),
    .o_empty    (w_l_empty),
    .o_full     (w_l_full),
    .o_ent_vld  (w_l_ent_vld),
    .o_ent_tag  (w_l_ent_tag)
  );

  assign w_f_vld = !w_f_empty;
  assign w_l_vld = !w_l_empty;

  // Two heads can share the cycle only as two singles to different registers
  assign w_conflict = w_f_head.dbl || w_l_head.dbl ||
                      ({w_f_head.bank, w_f_head.dst} == {w_l_head.bank, w_l_head.dst});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rr_ptr <= RR_FPU;
    else       r_rr_ptr <= w_rr_next;
  end

  // Retire decision; the pointer only moves when a conflict was resolved
  always_comb begin
    w_f_pop   = 1'b0;
    w_l_pop   = 1'b0;
    w_rr_next = r_rr_ptr;
    if (w_f_vld && w_l_vld) begin
      if (!w_conflict) begin
        w_f_pop = 1'b1;
        w_l_pop = 1'b1;
      end else if (r_rr_ptr == RR_FPU) begin
        w_f_pop   = 1'b1;
        w_rr_next = RR_LSU;
      end else begin
        w_l_pop   = 1'b1;
        w_rr_next = RR_FPU;
      end
    end else begin
      w_f_pop = w_f_vld;
      w_l_pop = w_l_vld;
    end
  end

  // Port steering; idle ports are fully zeroed
  always_comb begin
    w_wen0   = 1'b0;
    w_wdst0  = '0;
    w_wbank0 = 1'b0;
    w_wdata0 = '0;
    w_wen1   = 1'b0;
    w_wdst1  = '0;
    w_wbank1 = 1'b0;
    w_wdata1 = '0;
    w_sel    = w_f_pop ? w_f_head : w_l_head;
    if (w_f_pop && w_l_pop) begin
      w_wen0   = 1'b1;
      w_wdst0  = w_f_head.dst;
      w_wbank0 = w_f_head.bank;
      w_wdata0 = w_f_head.data[31:0];
      w_wen1   = 1'b1;
      w_wdst1  = w_l_head.dst;
      w_wbank1 = w_l_head.bank;
      w_wdata1 = w_l_head.data[31:0];
    end else if (w_f_pop || w_l_pop) begin
      w_wen0   = 1'b1;
      w_wbank0 = w_sel.bank;
      if (w_sel.dbl) begin
        // Even register takes the high word, odd register the low word
        w_wdst0  = {w_sel.dst[3:1], 1'b0};
        w_wdata0 = w_sel.data[63:32];
        w_wen1   = 1'b1;
        w_wdst1  = {w_sel.dst[3:1], 1'b1};
        w_wbank1 = w_sel.bank;
        w_wdata1 = w_sel.data[31:0];
      end else begin
        w_wdst0  = w_sel.dst;
        w_wdata0 = w_sel.data[31:0];
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_f_ent_vld[i])
        w_busy = w_busy | busy_mask(w_f_ent_tag[i][5], w_f_ent_tag[i][4], w_f_ent_tag[i][3:0]);
      if (w_l_ent_vld[i])
        w_busy = w_busy | busy_mask(w_l_ent_tag[i][5], w_l_ent_tag[i][4], w_l_ent_tag[i][3:0]);
    end
  end

  assign io_wb.fpu_wb_ready = !w_f_full;
  assign io_wb.lsu_wb_ready = !w_l_full;
  assign io_wb.rf_wen0      = w_wen0;
  assign io_wb.rf_wdst0     = w_wdst0;
  assign io_wb.rf_wbank0    = w_wbank0;
  assign io_wb.rf_wdata0    = w_wdata0;
  assign io_wb.rf_wen1      = w_wen1;
  assign io_wb.rf_wdst1     = w_wdst1;
  assign io_wb.rf_wbank1    = w_wbank1;
  assign io_wb.rf_wdata1    = w_wdata1;
  assign io_wb.wb_busy      = w_busy;
  assign io_wb.wb_idle      = w_f_empty && w_l_empty;

endmodule

// File: tb/tb_sh4_fpwb.sv
// Directed bench for sh4_fpwb: hand-computed port values per cycle, a shadow
// FPRF fed from the write ports, and an ordered write log for the stress run.
module tb_sh4_fpwb;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  sh4_fpwb_if wb ();

  sh4_fpwb dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_wb (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] fprf [32];
  logic        log_en;
  logic [36:0] wlog [$];

  // Shadow register file and write log, sampled mid-cycle
  always @(negedge clk) begin
    if (wb.rf_wen0) begin
      fprf[{wb.rf_wbank0, wb.rf_wdst0}] = wb.rf_wdata0;
      if (log_en) wlog.push_back({wb.rf_wbank0, wb.rf_wdst0, wb.rf_wdata0});
    end
    if (wb.rf_wen1) begin
      fprf[{wb.rf_wbank1, wb.rf_wdst1}] = wb.rf_wdata1;
      if (log_en) wlog.push_back({wb.rf_wbank1, wb.rf_wdst1, wb.rf_wdata1});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.fpu_wb_valid = 1'b0; wb.fpu_wb_dst = '0; wb.fpu_wb_bank = 1'b0;
    wb.fpu_wb_dbl = 1'b0; wb.fpu_wb_data = '0;
    wb.lsu_wb_valid = 1'b0; wb.lsu_wb_dst = '0; wb.lsu_wb_bank = 1'b0;
    wb.lsu_wb_dbl = 1'b0; wb.lsu_wb_data = '0;
  endtask

  task automatic fpu_put(input logic [3:0] dst, input logic bank, input logic dbl,
                         input logic [63:0] data);
    wb.fpu_wb_valid = 1'b1; wb.fpu_wb_dst = dst; wb.fpu_wb_bank = bank;
    wb.fpu_wb_dbl = dbl; wb.fpu_wb_data = data;
  endtask

  task automatic lsu_put(input logic [3:0] dst, input logic bank, input logic dbl,
                         input logic [63:0] data);
    wb.lsu_wb_valid = 1'b1; wb.lsu_wb_dst = dst; wb.lsu_wb_bank = bank;
    wb.lsu_wb_dbl = dbl; wb.lsu_wb_data = data;
  endtask

  task automatic chk_p0(input string tag, input logic [3:0] dst, input logic bank,
                        input logic [31:0] data);
    chk({tag, ".wen0"},   wb.rf_wen0,   1);
    chk({tag, ".wdst0"},  wb.rf_wdst0,  dst);
    chk({tag, ".wbank0"}, wb.rf_wbank0, bank);
    chk({tag, ".wdata0"}, wb.rf_wdata0, data);
  endtask

  task automatic chk_p1(input string tag, input logic [3:0] dst, input logic bank,
                        input logic [31:0] data);
    chk({tag, ".wen1"},   wb.rf_wen1,   1);
    chk({tag, ".wdst1"},  wb.rf_wdst1,  dst);
    chk({tag, ".wbank1"}, wb.rf_wbank1, bank);
    chk({tag, ".wdata1"}, wb.rf_wdata1, data);
  endtask

  task automatic chk_p1_off(input string tag);
    chk({tag, ".wen1"},   wb.rf_wen1,   0);
    chk({tag, ".wdst1"},  wb.rf_wdst1,  0);
    chk({tag, ".wdata1"}, wb.rf_wdata1, 0);
  endtask

  initial begin
    int  fi, li, fk, lk;
    logic f_acc, l_acc, saw_f_full, saw_l_full;
    logic [36:0] e;

    n_chk = 0; n_fail = 0; log_en = 1'b0;
    rst = 1'b1;
    idle_inputs();
    #1;
    // Reset state
    chk("rst.wen0", wb.rf_wen0, 0);
    chk("rst.wen1", wb.rf_wen1, 0);
    chk("rst.wdst0", wb.rf_wdst0, 0);
    chk("rst.wdata0", wb.rf_wdata0, 0);
    chk("rst.wbank1", wb.rf_wbank1, 0);
    chk("rst.busy", wb.wb_busy, 0);
    chk("rst.idle", wb.wb_idle, 1);
    chk("rst.fpu_rdy", wb.fpu_wb_ready, 1);
    chk("rst.lsu_rdy", wb.lsu_wb_ready, 1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: FPU single FR3
    fpu_put(4'd3, 1'b0, 1'b0, 64'h0000_0000_3F80_0000);
    tick(); idle_inputs();
    chk_p0("t1", 4'd3, 1'b0, 32'h3F80_0000);
    chk_p1_off("t1");
    chk("t1.busy", wb.wb_busy, 32'h0000_0008);
    chk("t1.idle", wb.wb_idle, 0);
    tick();
    chk("t1.wen0_after", wb.rf_wen0, 0);
    chk("t1.busy_after", wb.wb_busy, 0);
    chk("t1.idle_after", wb.wb_idle, 1);
    chk("t1.fprf3", fprf[3], 32'h3F80_0000);

    // 2: LSU double XF4/XF5
    lsu_put(4'd5, 1'b1, 1'b1, 64'h4009_21FB_5444_2D18);
    tick(); idle_inputs();
    chk_p0("t2", 4'd4, 1'b1, 32'h4009_21FB);
    chk_p1("t2", 4'd5, 1'b1, 32'h5444_2D18);
    chk("t2.busy", wb.wb_busy, 32'h0030_0000);
    tick();
    chk("t2.wen0_after", wb.rf_wen0, 0);
    chk("t2.wen1_after", wb.rf_wen1, 0);
    chk("t2.busy_after", wb.wb_busy, 0);
    chk("t2.xf4", fprf[20], 32'h4009_21FB);
    chk("t2.xf5", fprf[21], 32'h5444_2D18);

    // 3: two non-conflicting singles retire together
    fpu_put(4'd2, 1'b0, 1'b0, 64'hA);
    lsu_put(4'd7, 1'b0, 1'b0, 64'hB);
    tick(); idle_inputs();
    chk_p0("t3", 4'd2, 1'b0, 32'hA);
    chk_p1("t3", 4'd7, 1'b0, 32'hB);
    chk("t3.busy", wb.wb_busy, 32'h0000_0084);
    tick();
    chk("t3.idle", wb.wb_idle, 1);
    chk("t3.rr", dut.r_rr_ptr, 0);

    // 4: two doubles, FPU first, then repeated with LSU first
    fpu_put(4'd0, 1'b0, 1'b1, 64'h1111_1111_2222_2222);
    lsu_put(4'd8, 1'b0, 1'b1, 64'h3333_3333_4444_4444);
    tick(); idle_inputs();
    chk_p0("t4a.c1", 4'd0, 1'b0, 32'h1111_1111);
    chk_p1("t4a.c1", 4'd1, 1'b0, 32'h2222_2222);
    chk("t4a.busy1", wb.wb_busy, 32'h0000_0303);
    tick();
    chk_p0("t4a.c2", 4'd8, 1'b0, 32'h3333_3333);
    chk_p1("t4a.c2", 4'd9, 1'b0, 32'h4444_4444);
    chk("t4a.busy2", wb.wb_busy, 32'h0000_0300);
    tick();
    chk("t4a.idle", wb.wb_idle, 1);
    fpu_put(4'd0, 1'b0, 1'b1, 64'h5555_5555_6666_6666);
    lsu_put(4'd8, 1'b0, 1'b1, 64'h7777_7777_8888_8888);
    tick(); idle_inputs();
    chk_p0("t4b.c1", 4'd8, 1'b0, 32'h7777_7777);
    chk_p1("t4b.c1", 4'd9, 1'b0, 32'h8888_8888);
    tick();
    chk_p0("t4b.c2", 4'd0, 1'b0, 32'h5555_5555);
    chk_p1("t4b.c2", 4'd1, 1'b0, 32'h6666_6666);
    tick();
    chk("t4b.rr", dut.r_rr_ptr, 0);

    // 5: same-register singles serialize, FPU first
    fpu_put(4'd6, 1'b0, 1'b0, 64'h1);
    lsu_put(4'd6, 1'b0, 1'b0, 64'h2);
    tick(); idle_inputs();
    chk_p0("t5.c1", 4'd6, 1'b0, 32'h1);
    chk_p1_off("t5.c1");
    chk("t5.busy", wb.wb_busy, 32'h0000_0040);
    tick();
    chk_p0("t5.c2", 4'd6, 1'b0, 32'h2);
    chk_p1_off("t5.c2");
    tick();
    chk("t5.fr6", fprf[6], 32'h2);
    chk("t5.idle", wb.wb_idle, 1);

    // 6: saturate both queues with doubles; FPU -> FR bank, LSU -> XF bank
    fi = 0; li = 0; saw_f_full = 1'b0; saw_l_full = 1'b0;
    wlog.delete();
    log_en = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (fi == 8 && li == 8 && wb.wb_idle) break;
      if (fi < 8) fpu_put(4'(2 * fi), 1'b0, 1'b1, {32'hF000_0000 | 32'(fi), 32'hF100_0000 | 32'(fi)});
      else wb.fpu_wb_valid = 1'b0;
      if (li < 8) lsu_put(4'(2 * li), 1'b1, 1'b1, {32'hA000_0000 | 32'(li), 32'hA100_0000 | 32'(li)});
      else wb.lsu_wb_valid = 1'b0;
      if (!wb.fpu_wb_ready) saw_f_full = 1'b1;
      if (!wb.lsu_wb_ready) saw_l_full = 1'b1;
      f_acc = wb.fpu_wb_valid && wb.fpu_wb_ready;
      l_acc = wb.lsu_wb_valid && wb.lsu_wb_ready;
      tick();
      if (f_acc) fi++;
      if (l_acc) li++;
    end
    idle_inputs();
    log_en = 1'b0;
    chk("t6.fpu_sent", fi, 8);
    chk("t6.lsu_sent", li, 8);
    chk("t6.drained", wb.wb_idle, 1);
    chk("t6.fpu_backpressure", saw_f_full, 1);
    chk("t6.lsu_backpressure", saw_l_full, 1);
    fk = 0; lk = 0;
    foreach (wlog[i]) begin
      e = wlog[i];
      if (e[36] == 1'b0) begin
        chk("t6.fpu_write", e,
            (fk < 16) ? {1'b0, 4'(fk), ((fk % 2) ? 32'hF100_0000 : 32'hF000_0000) | 32'(fk / 2)} : 37'h1F_FFFF_FFFF);
        fk++;
      end else begin
        chk("t6.lsu_write", e,
            (lk < 16) ? {1'b1, 4'(lk), ((lk % 2) ? 32'hA100_0000 : 32'hA000_0000) | 32'(lk / 2)} : 37'h1F_FFFF_FFFF);
        lk++;
      end
    end
    chk("t6.fpu_writes", fk, 16);
    chk("t6.lsu_writes", lk, 16);

    // 6b: reset while queues hold entries and producers keep pushing
    fpu_put(4'd2, 1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
    lsu_put(4'd4, 1'b1, 1'b1, 64'hCAFE_F00D_1234_5678);
    tick(); tick(); tick();
    chk("t6b.busy_pre", wb.wb_busy, 32'h0030_000C);
    rst = 1'b1;
    #1;
    chk("t6b.wen0", wb.rf_wen0, 0);
    chk("t6b.wen1", wb.rf_wen1, 0);
    chk("t6b.busy", wb.wb_busy, 0);
    chk("t6b.idle", wb.wb_idle, 1);
    chk("t6b.fpu_rdy", wb.fpu_wb_ready, 1);
    chk("t6b.lsu_rdy", wb.lsu_wb_ready, 1);
    tick();
    chk("t6b.wen0_hold", wb.rf_wen0, 0);
    chk("t6b.idle_hold", wb.wb_idle, 1);
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("t6b.idle_post", wb.wb_idle, 1);
    chk("t6b.busy_post", wb.wb_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
